osc_freq_monitor: RTL and testbench

//  Parametrised successor to the fabric oscillator wrapper: supervises NUM_CH oscillator

---
 rtl/osc_freq_monitor_pkg.sv | 18 +
 rtl/osc_ch_monitor.sv | 142 ++++++++++++++
 rtl/osc_freq_monitor.sv | 77 +++++++
 tb/tb_osc_freq_monitor.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/osc_freq_monitor_pkg.sv
// Shared types and sizing helpers for the oscillator frequency monitor and its
// per-channel supervisor.
package osc_freq_monitor_pkg;

  typedef enum logic [1:0] {
    UNKNOWN = 2'd0,
    OK      = 2'd1,
    FAIL    = 2'd2
  } ch_state_t;

  // Run counters only ever compare against window counts of 1..15.
  localparam int RUN_W = 4;

  function automatic int gate_width(input int cycles);
    return $clog2(cycles);
  endfunction

endpackage

// File: rtl/osc_ch_monitor.sv
// Per-channel oscillator supervisor: synchronise the raw source, count rising edges
// over the gate window driven by the top, and qualify the source with hysteresis.
module osc_ch_monitor
  import osc_freq_monitor_pkg::*;
#(
  parameter int CNT_W        = 16,
  parameter int OK_WINDOWS   = 2,
  parameter int FAIL_WINDOWS = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             osc_i,
  input  logic             clear_i,
  input  logic             eval_i,
  input  logic [CNT_W-1:0] lo_bound_i,
  input  logic [CNT_W-1:0] hi_bound_i,
  output logic [CNT_W-1:0] count_o,
  output logic             ok_o,
  output logic             fail_enter_o
);

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [RUN_W-1:0] RUN_MAX  = {RUN_W{1'b1}};
  localparam logic [RUN_W-1:0] OK_RUN   = RUN_W'(OK_WINDOWS);
  localparam logic [RUN_W-1:0] FAIL_RUN = RUN_W'(FAIL_WINDOWS);

  logic             sync1_q;
  logic             sync2_q;
  logic             hist_q;
  logic             edge_det;
  logic [CNT_W-1:0] edge_cnt_q;
  logic [CNT_W-1:0] edge_cnt_d;
  logic [CNT_W-1:0] win_cnt;
  logic [CNT_W-1:0] count_q;
  logic             in_range;
  logic [RUN_W-1:0] good_run_q;
  logic [RUN_W-1:0] good_run_d;
  logic [RUN_W-1:0] bad_run_q;
  logic [RUN_W-1:0] bad_run_d;
  ch_state_t        state_q;
  ch_state_t        state_d;
  logic             ok_q;
  logic             fail_enter_q;

  // osc_i is asynchronous; only sync2_q onwards may feed any logic.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      hist_q  <= 1'b0;
    end else begin
      sync1_q <= osc_i;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
    end
  end

  assign edge_det = sync2_q & ~hist_q;

  // win_cnt folds in an edge seen during the evaluation cycle itself.
  always_comb begin
    win_cnt = edge_cnt_q;
    if (edge_det && (edge_cnt_q != CNT_MAX)) begin
      win_cnt = edge_cnt_q + CNT_W'(1);
    end
    edge_cnt_d = win_cnt;
    if (clear_i || eval_i) begin
      edge_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      edge_cnt_q <= '0;
    end else begin
      edge_cnt_q <= edge_cnt_d;
    end
  end

  assign in_range = (win_cnt >= lo_bound_i) && (win_cnt <= hi_bound_i);

  always_comb begin
    good_run_d = '0;
    bad_run_d  = '0;
    if (in_range) begin
      good_run_d = (good_run_q == RUN_MAX) ? RUN_MAX : good_run_q + RUN_W'(1);
    end else begin
      bad_run_d = (bad_run_q == RUN_MAX) ? RUN_MAX : bad_run_q + RUN_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      UNKNOWN: begin
        if (good_run_d >= OK_RUN) begin
          state_d = OK;
        end else if (bad_run_d >= FAIL_RUN) begin
          state_d = FAIL;
        end
      end
      OK: begin
        if (bad_run_d >= FAIL_RUN) begin
          state_d = FAIL;
        end
      end
      FAIL: begin
        if (good_run_d >= OK_RUN) begin
          state_d = OK;
        end
      end
      default: state_d = UNKNOWN;
    endcase
  end

  // State, run lengths and all reported outputs move only on an evaluation strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= UNKNOWN;
      good_run_q   <= '0;
      bad_run_q    <= '0;
      count_q      <= '0;
      ok_q         <= 1'b0;
      fail_enter_q <= 1'b0;
    end else begin
      fail_enter_q <= 1'b0;
      if (eval_i) begin
        state_q      <= state_d;
        good_run_q   <= good_run_d;
        bad_run_q    <= bad_run_d;
        count_q      <= win_cnt;
        ok_q         <= (state_d == OK);
        fail_enter_q <= (state_d == FAIL) && (state_q != FAIL);
      end
    end
  end

  assign count_o      = count_q;
  assign ok_o         = ok_q;
  assign fail_enter_o = fail_enter_q;

endmodule

// File: rtl/osc_freq_monitor.sv
// Top level of the oscillator frequency monitor: owns the shared gate window and
// combines the per-channel results into the measurement and fault pulses.
module osc_freq_monitor
  import osc_freq_monitor_pkg::*;
#(
  parameter int NUM_CH       = 2,
  parameter int CNT_W        = 16,
  parameter int GATE_CYCLES  = 20000,
  parameter int OK_WINDOWS   = 2,
  parameter int FAIL_WINDOWS = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic [NUM_CH-1:0]       osc_in,
  input  logic [CNT_W-1:0]        lo_bound,
  input  logic [CNT_W-1:0]        hi_bound,
  output logic [NUM_CH*CNT_W-1:0] meas_count,
  output logic                    meas_valid,
  output logic [NUM_CH-1:0]       osc_ok,
  output logic                    fault_irq
);

  localparam int                GATE_W    = gate_width(GATE_CYCLES);
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);

  logic [GATE_W-1:0] gate_q;
  logic [GATE_W-1:0] gate_d;
  logic              eval;
  logic              clear;
  logic              valid_q;
  logic [NUM_CH-1:0] fail_enter;

  assign eval  = en && (gate_q == GATE_LAST);
  assign clear = ~en;

  // A disabled monitor parks the gate at 0 so re-enabling always starts a full window.
  always_comb begin
    gate_d = gate_q + GATE_W'(1);
    if (!en || (gate_q == GATE_LAST)) begin
      gate_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gate_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      gate_q  <= gate_d;
      valid_q <= eval;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    osc_ch_monitor #(
      .CNT_W        (CNT_W),
      .OK_WINDOWS   (OK_WINDOWS),
      .FAIL_WINDOWS (FAIL_WINDOWS)
    ) u_ch (
      .clk          (clk),
      .reset        (reset),
      .osc_i        (osc_in[i]),
      .clear_i      (clear),
      .eval_i       (eval),
      .lo_bound_i   (lo_bound),
      .hi_bound_i   (hi_bound),
      .count_o      (meas_count[i*CNT_W +: CNT_W]),
      .ok_o         (osc_ok[i]),
      .fail_enter_o (fail_enter[i])
    );
  end

  assign meas_valid = valid_q;
  assign fault_irq  = |fail_enter;

endmodule

// File: tb/tb_osc_freq_monitor.sv
// Self-checking bench for osc_freq_monitor: directed scenarios plus randomized
// oscillator periods and bounds, checked against a window-level behavioural model.
`timescale 1ns/1ps
module tb_osc_freq_monitor;

  localparam int NUM_CH   = 2;
  localparam int CNT_W    = 8;
  localparam int GATE     = 100;
  localparam int OKW      = 2;
  localparam int FAILW    = 3;
  localparam int SAT_W    = 4;
  localparam int ST_UNK   = 0;
  localparam int ST_GOOD  = 1;
  localparam int ST_BAD   = 2;

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    en;
  logic [NUM_CH-1:0]       oscIn;
  logic [CNT_W-1:0]        loBound;
  logic [CNT_W-1:0]        hiBound;
  logic [NUM_CH*CNT_W-1:0] measCount;
  logic                    measValid;
  logic [NUM_CH-1:0]       oscOk;
  logic                    faultIrq;
  logic [SAT_W-1:0]        satCount;
  logic                    satValid;
  logic                    satOk;
  logic                    satIrq;

  always #5 clk = ~clk;

  osc_freq_monitor #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .GATE_CYCLES(GATE),
    .OK_WINDOWS(OKW), .FAIL_WINDOWS(FAILW)
  ) dut (
    .clk(clk), .reset(reset), .en(en), .osc_in(oscIn),
    .lo_bound(loBound), .hi_bound(hiBound),
    .meas_count(measCount), .meas_valid(measValid),
    .osc_ok(oscOk), .fault_irq(faultIrq)
  );

  // Narrow-counter instance watching channel 0 to exercise saturation.
  osc_freq_monitor #(
    .NUM_CH(1), .CNT_W(SAT_W), .GATE_CYCLES(GATE),
    .OK_WINDOWS(OKW), .FAIL_WINDOWS(FAILW)
  ) satDut (
    .clk(clk), .reset(reset), .en(en), .osc_in(oscIn[0]),
    .lo_bound(4'd0), .hi_bound(4'd15),
    .meas_count(satCount), .meas_valid(satValid),
    .osc_ok(satOk), .fault_irq(satIrq)
  );

  int nTests = 0;
  int nFail  = 0;

  int period [NUM_CH];
  int phase  [NUM_CH];

  int   hist    [NUM_CH][3];
  int   acc     [NUM_CH];
  int   goodRun [NUM_CH];
  int   badRun  [NUM_CH];
  int   mState  [NUM_CH];
  int   expCount[NUM_CH];
  logic [NUM_CH-1:0] expOk;
  logic expValid;
  logic expIrq;
  int   winLen;
  int   rawAcc0;
  int   expSat;
  int   satGood;
  logic expSatOk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nTests++;
    assert (obs === exp) else begin
      nFail++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    for (int c = 0; c < NUM_CH; c++) begin
      for (int k = 0; k < 3; k++) hist[c][k] = 0;
      acc[c] = 0; goodRun[c] = 0; badRun[c] = 0;
      mState[c] = ST_UNK; expCount[c] = 0;
    end
    expOk = '0; expValid = 1'b0; expIrq = 1'b0;
    winLen = 0; rawAcc0 = 0; expSat = 0; satGood = 0; expSatOk = 1'b0;
  endtask

  // Window-level model: an input rise becomes a counted edge two cycles later.
  task automatic modelStep();
    int  det [NUM_CH];
    bit  inRange;
    int  prev;
    for (int c = 0; c < NUM_CH; c++) begin
      det[c] = (hist[c][1] == 1 && hist[c][2] == 0) ? 1 : 0;
      hist[c][2] = hist[c][1];
      hist[c][1] = hist[c][0];
      hist[c][0] = oscIn[c] ? 1 : 0;
    end
    expValid = 1'b0;
    expIrq   = 1'b0;
    if (reset) begin
      modelReset();
    end else if (!en) begin
      winLen = 0; rawAcc0 = 0;
      for (int c = 0; c < NUM_CH; c++) acc[c] = 0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) acc[c] = (acc[c] + det[c] > 255) ? 255 : acc[c] + det[c];
      rawAcc0 += det[0];
      winLen++;
      if (winLen == GATE) begin
        for (int c = 0; c < NUM_CH; c++) begin
          inRange = (int'(loBound) <= acc[c]) && (acc[c] <= int'(hiBound));
          if (inRange) begin
            goodRun[c] = (goodRun[c] < 15) ? goodRun[c] + 1 : 15;
            badRun[c]  = 0;
          end else begin
            badRun[c]  = (badRun[c] < 15) ? badRun[c] + 1 : 15;
            goodRun[c] = 0;
          end
          prev = mState[c];
          if (mState[c] != ST_GOOD && goodRun[c] >= OKW) mState[c] = ST_GOOD;
          else if (mState[c] != ST_BAD && badRun[c] >= FAILW) mState[c] = ST_BAD;
          if (prev != ST_BAD && mState[c] == ST_BAD) expIrq = 1'b1;
          expCount[c] = acc[c];
          expOk[c]    = (mState[c] == ST_GOOD);
          acc[c]      = 0;
        end
        expSat   = (rawAcc0 > 15) ? 15 : rawAcc0;
        satGood  = satGood + 1;
        expSatOk = (satGood >= OKW);
        rawAcc0  = 0;
        expValid = 1'b1;
        winLen   = 0;
      end
    end
  endtask

  task automatic setPeriod(input int c, input int p);
    period[c] = p;
    phase[c]  = 0;
    oscIn[c]  = (p != 0);
  endtask

  // One clock: update the model with this cycle's inputs, then compare after the edge.
  task automatic applyStimulus();
    modelStep();
    @(posedge clk);
    #1;
    checkOutput("meas_valid", {31'd0, measValid}, {31'd0, expValid});
    checkOutput("fault_irq", {31'd0, faultIrq}, {31'd0, expIrq});
    checkOutput("osc_ok", 32'(oscOk), 32'(expOk));
    for (int c = 0; c < NUM_CH; c++)
      checkOutput($sformatf("meas_count%0d", c), 32'(measCount[c*CNT_W +: CNT_W]), 32'(expCount[c]));
    checkOutput("sat_valid", {31'd0, satValid}, {31'd0, expValid});
    checkOutput("sat_count", 32'(satCount), 32'(expSat));
    checkOutput("sat_ok", {31'd0, satOk}, {31'd0, expSatOk});
    checkOutput("sat_irq", {31'd0, satIrq}, 32'd0);
    for (int c = 0; c < NUM_CH; c++) begin
      if (period[c] == 0) begin
        oscIn[c] = 1'b0;
      end else begin
        phase[c] = (phase[c] + 1) % period[c];
        oscIn[c] = (phase[c] < period[c] / 2);
      end
    end
  endtask

  task automatic runWindows(input int n);
    int seen   = 0;
    int budget = (n + 2) * GATE;
    while (seen < n && budget > 0) begin
      applyStimulus();
      if (expValid) seen++;
      budget--;
    end
    checkOutput("window_budget", 32'(seen), 32'(n));
  endtask

  initial begin
    int k;
    int p;
    int lo;
    modelReset();
    reset = 1'b1; en = 1'b0; oscIn = '0;
    loBound = 8'd24; hiBound = 8'd26;
    for (int c = 0; c < NUM_CH; c++) begin period[c] = 0; phase[c] = 0; end

    repeat (3) applyStimulus();
    checkOutput("rst_count", 32'(measCount), 32'd0);
    checkOutput("rst_ok", 32'(oscOk), 32'd0);
    checkOutput("rst_valid", {31'd0, measValid}, 32'd0);
    checkOutput("rst_irq", {31'd0, faultIrq}, 32'd0);

    // Clock present on ch0, stopped on ch1.
    reset = 1'b0; en = 1'b1;
    setPeriod(0, 4); setPeriod(1, 0);
    runWindows(1);
    checkOutput("ok_after_1", 32'(oscOk), 32'd0);
    checkOutput("count0_w1", 32'(measCount[7:0]), 32'd25);
    runWindows(1);
    checkOutput("ok_after_2", 32'(oscOk), 32'd1);
    checkOutput("sat_15", 32'(satCount), 32'd15);
    runWindows(1);
    checkOutput("ch1_fail_irq", {31'd0, faultIrq}, 32'd1);
    checkOutput("ch1_count0", 32'(measCount[15:8]), 32'd0);
    checkOutput("ch1_not_ok", 32'(oscOk), 32'd1);

    // Hysteresis: two dead windows keep OK, the third fails.
    setPeriod(0, 0);
    runWindows(2);
    checkOutput("hyst_hold", 32'(oscOk), 32'd1);
    runWindows(1);
    checkOutput("hyst_fail_ok", 32'(oscOk), 32'd0);
    checkOutput("hyst_fail_irq", {31'd0, faultIrq}, 32'd1);
    setPeriod(0, 4);
    runWindows(1);
    checkOutput("recover_1", 32'(oscOk), 32'd0);
    runWindows(1);
    checkOutput("recover_2", 32'(oscOk), 32'd1);

    // Inverted bounds make every window out of range.
    loBound = 8'd20; hiBound = 8'd10;
    runWindows(3);
    checkOutput("inverted_ok", 32'(oscOk), 32'd0);
    checkOutput("inverted_irq", {31'd0, faultIrq}, 32'd1);
    loBound = 8'd24; hiBound = 8'd26;
    runWindows(2);
    checkOutput("restored_ok", 32'(oscOk), 32'd1);

    // Enable dropped mid-window: partial window is discarded.
    repeat (50) applyStimulus();
    en = 1'b0;
    repeat (30) applyStimulus();
    en = 1'b1;
    k = 0;
    do begin
      applyStimulus();
      k++;
    end while (!measValid && k < 2 * GATE);
    checkOutput("reenable_latency", 32'(k), 32'd100);
    checkOutput("reenable_count", 32'(measCount[7:0]), 32'd25);
    checkOutput("reenable_ok_held", 32'(oscOk), 32'd1);

    // Randomized periods and bounds, one window each.
    for (int w = 0; w < 10; w++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        p = $urandom_range(0, 9);
        setPeriod(c, (p == 0) ? 0 : p + 3);
      end
      lo = $urandom_range(0, 30);
      loBound = 8'(lo);
      hiBound = ($urandom_range(0, 5) == 0) ? 8'($urandom_range(0, lo)) : 8'(lo + $urandom_range(0, 8));
      runWindows(1);
    end

    // Reset in the middle of a window while qualified OK.
    loBound = 8'd24; hiBound = 8'd26;
    setPeriod(0, 4); setPeriod(1, 4);
    runWindows(3);
    checkOutput("pre_reset_ok", 32'(oscOk), 32'd3);
    repeat (40) applyStimulus();
    reset = 1'b1;
    applyStimulus();
    reset = 1'b0;
    checkOutput("reset_mid_ok", 32'(oscOk), 32'd0);
    checkOutput("reset_mid_count", 32'(measCount), 32'd0);
    runWindows(1);
    checkOutput("reset_1win", 32'(oscOk), 32'd0);
    runWindows(1);
    checkOutput("reset_2win", 32'(oscOk), 32'd3);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
